// File: rtl/sum_step_checker_pkg.sv
// Shared types and helpers for the sum step checker.
// State encoding and step truncation live here.
package sum_step_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  function automatic logic [31:0] trunc_step(
    input int step,
    input int size
  );
    logic [31:0] mask;
    mask = (32'd1 << size) - 32'd1;
    return 32'(step) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sum_step_checker.sv
// Monitors a counter sum for a constant modular step.
// Locks after LOCK_CNT good deltas; faults on a later miss.
module sum_step_checker
  import sum_step_checker_pkg::*;
#(
  parameter int SIZE     = 10,
  parameter int STEP     = 2,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [SIZE-1:0]  q,
  output logic [SIZE-1:0]  delta,
  output logic             locked,
  output logic             fault,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [SIZE-1:0] STEP_T =
    SIZE'(trunc_step(STEP, SIZE));
  localparam int MW = $clog2(LOCK_CNT + 1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] q_prev_q, q_prev_d;
  logic [SIZE-1:0] delta_q, delta_d;
  logic [MW-1:0]   match_cnt_q, match_cnt_d;
  logic            wrap_pulse_q, wrap_pulse_d;
  logic            wrap_inc, err_inc;
  logic [SIZE-1:0] diff;
  logic            match;
  logic            wrap;
  logic            lock_hit;

  assign diff     = q - q_prev_q;
  assign match    = (diff == STEP_T);
  assign wrap     = (q < q_prev_q);
  assign lock_hit =
    ((32'(match_cnt_q) + 32'd1) == 32'(LOCK_CNT));

  always_comb begin
    state_d      = state_q;
    q_prev_d     = q_prev_q;
    delta_d      = delta_q;
    match_cnt_d  = match_cnt_q;
    wrap_pulse_d = 1'b0;
    wrap_inc     = 1'b0;
    err_inc      = 1'b0;
    if (clr) begin
      state_d     = IDLE;
      match_cnt_d = '0;
    end else if (en) begin
      if (state_q == IDLE) begin
        q_prev_d    = q;
        match_cnt_d = '0;
        state_d     = ARMED;
      end else begin
        q_prev_d     = q;
        delta_d      = diff;
        wrap_pulse_d = wrap;
        wrap_inc     = wrap;
      end
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (match) begin
            match_cnt_d = match_cnt_q + MW'(1);
            if (lock_hit) begin
              state_d = LOCKED;
            end
          end else begin
            match_cnt_d = '0;
            err_inc     = 1'b1;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d = FAULT;
            err_inc = 1'b1;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      q_prev_q     <= '0;
      delta_q      <= '0;
      match_cnt_q  <= '0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_prev_q     <= q_prev_d;
      delta_q      <= delta_d;
      match_cnt_q  <= match_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_inc),
    .cnt (wrap_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign delta      = delta_q;
  assign locked     = (state_q == LOCKED);
  assign fault      = (state_q == FAULT);
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_sum_step_checker.sv
// Self-checking bench: directed plan plus random stimulus
// compared each cycle against a behavioural model.
module tb_sum_step_checker;

  localparam int SIZE     = 4;
  localparam int STEP     = 2;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 3;
  localparam int MOD      = 1 << SIZE;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             clr = 1'b0;
  logic [SIZE-1:0]  q   = '0;
  logic [SIZE-1:0]  delta;
  logic             locked;
  logic             fault;
  logic             wrap_pulse;
  logic [CNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model: mode 0 idle, 1 armed, 2 locked, 3 fault
  int m_mode, m_prev, m_delta, m_run;
  int m_wc, m_ec, m_wp;

  sum_step_checker #(
    .SIZE(SIZE), .STEP(STEP),
    .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .q(q),
    .delta(delta), .locked(locked), .fault(fault),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model(input bit r, input bit c,
                       input bit e, input int qv);
    int  d;
    bit  ok;
    if (r) begin
      m_mode = 0; m_prev = 0; m_delta = 0; m_run = 0;
      m_wc = 0; m_ec = 0; m_wp = 0;
    end else if (c) begin
      m_mode = 0; m_run = 0; m_wc = 0; m_ec = 0; m_wp = 0;
    end else if (!e) begin
      m_wp = 0;
    end else if (m_mode == 0) begin
      m_prev = qv; m_run = 0; m_mode = 1; m_wp = 0;
    end else begin
      d  = (qv - m_prev + MOD) % MOD;
      ok = (d == (STEP % MOD));
      m_wp    = (qv < m_prev) ? 1 : 0;
      m_delta = d;
      if (m_wp != 0) m_wc = sat_inc(m_wc);
      m_prev = qv;
      if (m_mode == 1) begin
        if (ok) begin
          m_run++;
          if (m_run == LOCK_CNT) m_mode = 2;
        end else begin
          m_run = 0;
          m_ec  = sat_inc(m_ec);
        end
      end else if (m_mode == 2 && !ok) begin
        m_mode = 3;
        m_ec   = sat_inc(m_ec);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c,
                     input bit e, input int qv);
    @(negedge clk);
    rst = r; clr = c; en = e; q = SIZE'(qv);
    @(posedge clk);
    model(r, c, e, qv);
    #1;
    chk("delta", int'(delta), m_delta);
    chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
    chk("fault", int'(fault), (m_mode == 3) ? 1 : 0);
    chk("wrap_pulse", int'(wrap_pulse), m_wp);
    chk("wrap_cnt", int'(wrap_cnt), m_wc);
    chk("err_cnt", int'(err_cnt), m_ec);
  endtask

  initial begin
    int nq;
    cyc(1, 0, 0, 0);
    chk("rst_locked", int'(locked), 0);
    // lock-in
    for (int i = 0; i <= 8; i += 2) cyc(0, 0, 1, i);
    chk("lock_in", int'(locked), 1);
    chk("lock_delta", int'(delta), 2);
    // wrap
    cyc(0, 0, 1, 10); cyc(0, 0, 1, 12);
    cyc(0, 0, 1, 14); cyc(0, 0, 1, 0);
    chk("wrap_seen", int'(wrap_pulse), 1);
    cyc(0, 0, 1, 2);
    chk("wrap_once", int'(wrap_pulse), 0);
    // fault then sticky then clr
    cyc(0, 0, 1, 5);
    chk("fault_delta", int'(delta), 3);
    cyc(0, 0, 1, 7);
    chk("fault_sticky", int'(fault), 1);
    cyc(0, 1, 0, 7);
    // ARMED mismatch
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 2); cyc(0, 0, 1, 4);
    cyc(0, 0, 1, 7);
    chk("no_lock_7", int'(locked), 0);
    for (int i = 9; i <= 15; i += 2) cyc(0, 0, 1, i);
    chk("relock_15", int'(locked), 1);
    // en gating
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, int'($urandom_range(0, MOD - 1)));
    cyc(0, 0, 1, 1);
    chk("gap_locked", int'(locked), 1);
    // five wraps then fault, then rst+clr+en
    cyc(0, 1, 0, 0);
    for (int i = 0; i <= 40; i++) cyc(0, 0, 1, (2 * i) % MOD);
    chk("wrap_five", int'(wrap_cnt), 5);
    cyc(0, 0, 1, 5);
    cyc(1, 1, 1, 9);
    chk("prio_rst", int'(wrap_cnt), 0);
    // clr+en in LOCKED: no sample taken
    for (int i = 0; i <= 8; i += 2) cyc(0, 0, 1, i);
    cyc(0, 1, 1, 10);
    cyc(0, 0, 1, 3);
    chk("clr_no_sample", int'(delta), 2);
    // saturation of wrap_cnt
    for (int i = 0; i < 80; i++) cyc(0, 0, 1, (2 * i) % MOD);
    chk("wrap_sat", int'(wrap_cnt), SAT);
    // random
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 85)
        nq = (m_prev + STEP) % MOD;
      else
        nq = int'($urandom_range(0, MOD - 1));
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 99) < 80, nq);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
